// File: rtl/poly_operand_regfile_pkg.sv
// Shared POLY datapath constants, sel encodings and result address base.
// Imported by the operand register file and its shift-in sub-module.
package POLY_pkg;

  localparam int POLY_WW = 17;
  localparam int POLY_N  = 5;
  localparam int POLY_S  = 4;

  localparam int OP_WORDS      = POLY_N * POLY_S;
  localparam int MP0_WORDS     = POLY_N;
  localparam int RES_BASE_ADDR = 3 * POLY_N * POLY_S + POLY_N;

  typedef enum logic [1:0] {
    SEL_A   = 2'd0,
    SEL_B   = 2'd1,
    SEL_M   = 2'd2,
    SEL_MP0 = 2'd3
  } sel_e;

endpackage

// File: rtl/word_shift_in_reg.sv
// Top-in shift register with saturating word counter and overflow flag.
// full/ovf are exported as next-state values so a same-cycle check sees them.
module word_shift_in_reg #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 20
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   clear_i,
  input  logic                   en_i,
  input  logic [WIDTH-1:0]       din_i,
  output logic [DEPTH*WIDTH-1:0] data_o,
  output logic                   full_nxt_o,
  output logic                   ovf_nxt_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TOP = DEPTH * WIDTH;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_d;
  logic          ovf_q;
  logic          ovf_base;
  logic          ovf_d;
  logic          shift;

  always_comb begin
    cnt_base   = clear_i ? '0 : cnt_q;
    ovf_base   = clear_i ? 1'b0 : ovf_q;
    shift      = en_i && (cnt_base != CW'(DEPTH));
    cnt_d      = shift ? cnt_base + 1'b1 : cnt_base;
    ovf_d      = ovf_base | (en_i & ~shift);
    full_nxt_o = (cnt_d == CW'(DEPTH));
    ovf_nxt_o  = ovf_d;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      data_o <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      if (shift)
        data_o <= {din_i, data_o[TOP-1:WIDTH]};
    end
  end

endmodule

// File: rtl/poly_operand_regfile.sv
// Operand deserialiser (A, B, M, M'0) and result serialiser
// sitting between the POLY memory controller and the multiplier.
module poly_operand_regfile
  import POLY_pkg::*;
#(
  parameter int WORD_WIDTH = POLY_WW,
  parameter int N          = POLY_N,
  parameter int S          = POLY_S
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic [WORD_WIDTH-1:0]     BRAM_dout_i,
  input  logic [1:0]                INPUT_reg_sel_i,
  input  logic                      INPUT_reg_en_i,
  input  logic                      load_done_i,
  input  logic                      RES_load_i,
  input  logic [N*S*WORD_WIDTH-1:0] RES_i,
  input  logic                      RES_reg_shift_i,
  output logic [WORD_WIDTH-1:0]     BRAM_din_o,
  output logic [N*S*WORD_WIDTH-1:0] A_o,
  output logic [N*S*WORD_WIDTH-1:0] B_o,
  output logic [N*S*WORD_WIDTH-1:0] M_o,
  output logic [N*WORD_WIDTH-1:0]   M_prime_0_o,
  output logic                      operands_valid_o,
  output logic                      load_error_o,
  output logic                      res_busy_o
);

  localparam int WW  = WORD_WIDTH;
  localparam int NS  = N * S;
  localparam int RCW = $clog2(NS + 1);

  logic       loading;
  logic       start;
  logic [3:0] en_vec;
  logic [3:0] full_nxt;
  logic [3:0] ovf_nxt;
  logic       all_ok;

  always_comb begin
    en_vec = '0;
    if (INPUT_reg_en_i) begin
      case (sel_e'(INPUT_reg_sel_i))
        SEL_A:   en_vec[0] = 1'b1;
        SEL_B:   en_vec[1] = 1'b1;
        SEL_M:   en_vec[2] = 1'b1;
        SEL_MP0: en_vec[3] = 1'b1;
        default: en_vec = '0;
      endcase
    end
  end

  assign start  = INPUT_reg_en_i && !loading;
  assign all_ok = (&full_nxt) && !(|ovf_nxt);

  word_shift_in_reg #(.WIDTH(WW), .DEPTH(NS)) u_reg_a (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(start),
    .en_i(en_vec[0]), .din_i(BRAM_dout_i), .data_o(A_o),
    .full_nxt_o(full_nxt[0]), .ovf_nxt_o(ovf_nxt[0])
  );

  word_shift_in_reg #(.WIDTH(WW), .DEPTH(NS)) u_reg_b (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(start),
    .en_i(en_vec[1]), .din_i(BRAM_dout_i), .data_o(B_o),
    .full_nxt_o(full_nxt[1]), .ovf_nxt_o(ovf_nxt[1])
  );

  word_shift_in_reg #(.WIDTH(WW), .DEPTH(NS)) u_reg_m (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(start),
    .en_i(en_vec[2]), .din_i(BRAM_dout_i), .data_o(M_o),
    .full_nxt_o(full_nxt[2]), .ovf_nxt_o(ovf_nxt[2])
  );

  word_shift_in_reg #(.WIDTH(WW), .DEPTH(N)) u_reg_mp0 (
    .clock_i(clock_i), .reset_i(reset_i), .clear_i(start),
    .en_i(en_vec[3]), .din_i(BRAM_dout_i), .data_o(M_prime_0_o),
    .full_nxt_o(full_nxt[3]), .ovf_nxt_o(ovf_nxt[3])
  );

  // A done pulse with no open session (and no word opening one) is malformed
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      loading          <= 1'b0;
      operands_valid_o <= 1'b0;
      load_error_o     <= 1'b0;
    end else if (load_done_i) begin
      loading <= 1'b0;
      if (loading || INPUT_reg_en_i) begin
        operands_valid_o <= all_ok;
        load_error_o     <= !all_ok;
      end else begin
        operands_valid_o <= 1'b0;
        load_error_o     <= 1'b1;
      end
    end else if (start) begin
      loading          <= 1'b1;
      operands_valid_o <= 1'b0;
      load_error_o     <= 1'b0;
    end
  end

  logic [NS*WW-1:0] res_reg;
  logic [RCW-1:0]   res_cnt;
  logic [RCW-1:0]   res_cnt_d;

  always_comb begin
    res_cnt_d = res_cnt;
    if (RES_load_i)
      res_cnt_d = RCW'(NS);
    else if (RES_reg_shift_i && res_cnt != '0)
      res_cnt_d = res_cnt - 1'b1;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      res_reg    <= '0;
      res_cnt    <= '0;
      res_busy_o <= 1'b0;
    end else begin
      res_cnt    <= res_cnt_d;
      res_busy_o <= (res_cnt_d != '0);
      if (RES_load_i)
        res_reg <= RES_i;
      else if (RES_reg_shift_i)
        res_reg <= {{WW{1'b0}}, res_reg[NS*WW-1:WW]};
    end
  end

  assign BRAM_din_o = res_reg[WW-1:0];

endmodule

// File: tb/tb_poly_operand_regfile.sv
// Directed bench for poly_operand_regfile: operand loads, load errors,
// result serialisation, load/shift priority and mid-operation reset.
module tb_poly_operand_regfile;

  localparam int WW = 17;
  localparam int N  = 5;
  localparam int S  = 4;
  localparam int OB = N * S * WW;

  logic          clock_i = 1'b0;
  logic          reset_i;
  logic [WW-1:0] BRAM_dout_i;
  logic [1:0]    INPUT_reg_sel_i;
  logic          INPUT_reg_en_i;
  logic          load_done_i;
  logic          RES_load_i;
  logic [OB-1:0] RES_i;
  logic          RES_reg_shift_i;
  logic [WW-1:0] BRAM_din_o;
  logic [OB-1:0] A_o;
  logic [OB-1:0] B_o;
  logic [OB-1:0] M_o;
  logic [N*WW-1:0] M_prime_0_o;
  logic          operands_valid_o;
  logic          load_error_o;
  logic          res_busy_o;

  int nvec = 0;
  int nerr = 0;

  always #5 clock_i = ~clock_i;

  poly_operand_regfile #(.WORD_WIDTH(WW), .N(N), .S(S)) dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .BRAM_dout_i(BRAM_dout_i), .INPUT_reg_sel_i(INPUT_reg_sel_i),
    .INPUT_reg_en_i(INPUT_reg_en_i), .load_done_i(load_done_i),
    .RES_load_i(RES_load_i), .RES_i(RES_i),
    .RES_reg_shift_i(RES_reg_shift_i), .BRAM_din_o(BRAM_din_o),
    .A_o(A_o), .B_o(B_o), .M_o(M_o), .M_prime_0_o(M_prime_0_o),
    .operands_valid_o(operands_valid_o), .load_error_o(load_error_o),
    .res_busy_o(res_busy_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wd(input logic [OB-1:0] v, input int k);
    return 32'(v[k*WW +: WW]);
  endfunction

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // Words numbered from 1 in sel order A, B, M, M'0
  task automatic load(input int na, input int nb, input int nm,
                      input int np, input bit merge_done);
    int cnt[4];
    int w;
    int total;
    cnt[0] = na; cnt[1] = nb; cnt[2] = nm; cnt[3] = np;
    total = na + nb + nm + np;
    w = 1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < cnt[s]; i++) begin
        INPUT_reg_en_i  = 1'b1;
        INPUT_reg_sel_i = 2'(s);
        BRAM_dout_i     = WW'(w);
        load_done_i     = merge_done && (w == total);
        tick();
        w++;
      end
    end
    INPUT_reg_en_i = 1'b0;
    load_done_i    = 1'b0;
    if (!merge_done) begin
      load_done_i = 1'b1;
      tick();
      load_done_i = 1'b0;
    end
  endtask

  task automatic res_fill(input int base);
    for (int k = 0; k < N * S; k++)
      RES_i[k*WW +: WW] = WW'(base + k);
  endtask

  initial begin
    reset_i = 1'b1;
    BRAM_dout_i = '0;
    INPUT_reg_sel_i = '0;
    INPUT_reg_en_i = 1'b0;
    load_done_i = 1'b0;
    RES_load_i = 1'b0;
    RES_i = '0;
    RES_reg_shift_i = 1'b0;
    tick();
    tick();
    reset_i = 1'b0;
    chk("rst_valid", 32'(operands_valid_o), 0);
    chk("rst_err", 32'(load_error_o), 0);
    chk("rst_busy", 32'(res_busy_o), 0);
    chk("rst_A", 32'(|A_o), 0);

    // 1: nominal load
    load(20, 20, 20, 5, 1'b0);
    chk("t1_A0", wd(A_o, 0), 1);
    chk("t1_A19", wd(A_o, 19), 20);
    chk("t1_B0", wd(B_o, 0), 21);
    chk("t1_M19", wd(M_o, 19), 60);
    chk("t1_P0", wd(OB'(M_prime_0_o), 0), 61);
    chk("t1_P4", wd(OB'(M_prime_0_o), 4), 65);
    chk("t1_valid", 32'(operands_valid_o), 1);
    chk("t1_err", 32'(load_error_o), 0);

    // 2: short B burst, then a good burst
    load(20, 19, 20, 5, 1'b0);
    chk("t2_err", 32'(load_error_o), 1);
    chk("t2_valid", 32'(operands_valid_o), 0);
    load(20, 20, 20, 5, 1'b0);
    chk("t2_valid2", 32'(operands_valid_o), 1);
    chk("t2_err2", 32'(load_error_o), 0);

    // 3: one word too many to M'0
    load(20, 20, 20, 6, 1'b0);
    chk("t3_P0", wd(OB'(M_prime_0_o), 0), 61);
    chk("t3_P4", wd(OB'(M_prime_0_o), 4), 65);
    chk("t3_err", 32'(load_error_o), 1);
    chk("t3_valid", 32'(operands_valid_o), 0);

    // Stray done with no session open
    load_done_i = 1'b1;
    tick();
    load_done_i = 1'b0;
    chk("stray_err", 32'(load_error_o), 1);

    // 4: result serialisation
    res_fill(100);
    RES_load_i = 1'b1;
    tick();
    RES_load_i = 1'b0;
    chk("t4_busy0", 32'(res_busy_o), 1);
    for (int k = 0; k < N * S; k++) begin
      RES_reg_shift_i = 1'b1;
      chk($sformatf("t4_din%0d", k), 32'(BRAM_din_o), 32'(100 + k));
      chk($sformatf("t4_busy%0d", k), 32'(res_busy_o), 1);
      tick();
    end
    RES_reg_shift_i = 1'b0;
    chk("t4_busy_end", 32'(res_busy_o), 0);
    chk("t4_din_end", 32'(BRAM_din_o), 0);

    // 5: load wins over shift
    res_fill(100);
    RES_load_i = 1'b1;
    tick();
    RES_load_i = 1'b0;
    RES_reg_shift_i = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    res_fill(200);
    RES_load_i = 1'b1;
    tick();
    RES_load_i = 1'b0;
    chk("t5_din0", 32'(BRAM_din_o), 200);
    for (int k = 0; k < N * S - 1; k++) tick();
    chk("t5_din19", 32'(BRAM_din_o), 219);
    chk("t5_busy19", 32'(res_busy_o), 1);
    tick();
    RES_reg_shift_i = 1'b0;
    chk("t5_busy20", 32'(res_busy_o), 0);

    // 5b: done merged with the final word
    load(20, 20, 20, 5, 1'b1);
    chk("t5_valid", 32'(operands_valid_o), 1);
    chk("t5_err", 32'(load_error_o), 0);
    chk("t5_P4", wd(OB'(M_prime_0_o), 4), 65);

    // 6: reset mid-load and mid-store
    res_fill(300);
    RES_load_i = 1'b1;
    tick();
    RES_load_i = 1'b0;
    RES_reg_shift_i = 1'b1;
    for (int k = 0; k < 7; k++) tick();
    RES_reg_shift_i = 1'b0;
    chk("t6_din7", 32'(BRAM_din_o), 307);
    for (int w = 1; w <= 30; w++) begin
      INPUT_reg_en_i  = 1'b1;
      INPUT_reg_sel_i = (w <= 20) ? 2'd0 : 2'd1;
      BRAM_dout_i     = WW'(w + 500);
      tick();
    end
    INPUT_reg_en_i = 1'b0;
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    chk("t6_A", 32'(|A_o), 0);
    chk("t6_B", 32'(|B_o), 0);
    chk("t6_din", 32'(BRAM_din_o), 0);
    chk("t6_busy", 32'(res_busy_o), 0);
    chk("t6_valid", 32'(operands_valid_o), 0);
    chk("t6_err", 32'(load_error_o), 0);
    load(20, 20, 20, 5, 1'b0);
    chk("t6_valid2", 32'(operands_valid_o), 1);
    chk("t6_A0", wd(A_o, 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
